regfile_write_scheduler: RTL and testbench

- Sits between the writeback side of the pipeline and the 32x32 register file write port (RegWrite / Write_register / Write_data).
- Merges two write sources into that single port:
  - in-order WB stage: fixed priority, never stalled;
  - long-latency unit (mul/div, load-miss return): valid/ready handshake, buffered in a DEPTH-entry FIFO.
- Exports a pending-write scoreboard so the ID stage can stall RAW/WAW hazards on queued writes.

---
 rtl/regfile_write_scheduler.sv | 145 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: merges the in-order WB write stream and a
// handshaked long-latency write stream into the single register file
// write port. WB always has priority. Long-latency writes wait in a
// DEPTH-entry FIFO. A pending-write scoreboard feeds ID-stage hazard checks.
// Optional build macro: WSCHED_BYPASS_EN lets an lu write skip the empty
// FIFO and go straight into the output register.
module regfile_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic [31:0]   wb_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [4:0]    lu_rd,
    input  logic [31:0]   lu_data,
    input  logic [4:0]    chk_rs,
    input  logic [4:0]    chk_rt,
    output logic          hz_rs,
    output logic          hz_rt,
    output logic          RegWrite,
    output logic [4:0]    Write_register,
    output logic [31:0]   Write_data,
    output logic [AW:0]   q_count,
    output logic          waw_err
);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             wb_fire;
    logic             push;
    logic             push_fifo;
    logic             pop;
    logic             bypass;
    logic [DEPTH-1:0] valid_ent;
    logic [31:0]      pending;
    logic             waw_hit;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign lu_ready   = !reset && !fifo_full;
    assign wb_fire    = wb_valid && (wb_rd != 5'd0);
    // Handshakes to $0 complete but never occupy a slot.
    assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
    // WB owns the port this cycle; otherwise the head drains.
    assign pop        = !wb_fire && !fifo_empty;

`ifdef WSCHED_BYPASS_EN
    assign bypass     = push && fifo_empty && !wb_fire;
`else
    assign bypass     = 1'b0;
`endif

    assign push_fifo  = push && !bypass;
    assign q_count    = count;

    // Slot validity, pending-register vector and WB-vs-queue collision.
    always_comb begin
        valid_ent = '0;
        pending   = '0;
        waw_hit   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // An entry is live when its distance from the head is below the occupancy.
            valid_ent[i] = ({1'b0, AW'(AW'(i) - rptr)} < count);
            if (valid_ent[i]) begin
                pending[rd_q[i]] = 1'b1;
                if (rd_q[i] == wb_rd)
                    waw_hit = 1'b1;
            end
        end
        // The register file only commits at the end of the RegWrite cycle.
        if (RegWrite)
            pending[Write_register] = 1'b1;
    end

    assign hz_rs = (chk_rs != 5'd0) && pending[chk_rs];
    assign hz_rt = (chk_rt != 5'd0) && pending[chk_rt];

    // FIFO storage; validity comes from count, so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            rd_q[wptr]   <= lu_rd;
            data_q[wptr] <= lu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push_fifo)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({push_fifo, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: WB, then FIFO head, then bypassed lu write.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
        end else if (wb_fire) begin
            RegWrite       <= 1'b1;
            Write_register <= wb_rd;
            Write_data     <= wb_data;
        end else if (!fifo_empty) begin
            RegWrite       <= 1'b1;
            Write_register <= rd_q[rptr];
            Write_data     <= data_q[rptr];
        end else if (bypass) begin
            RegWrite       <= 1'b1;
            Write_register <= lu_rd;
            Write_data     <= lu_data;
        end else begin
            RegWrite       <= 1'b0;
        end
    end

    // Sticky WAW collision flag.
    always_ff @(posedge clk) begin
        if (reset)
            waw_err <= 1'b0;
        else if (wb_fire && waw_hit)
            waw_err <= 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed scenarios with literal expectations,
// followed by randomized traffic, all checked every cycle against a
// queue-based reference model of the write scheduler.
module tb_regfile_write_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_rd;
    logic [31:0]   lu_data;
    logic [4:0]    chk_rs;
    logic [4:0]    chk_rt;
    logic          hz_rs;
    logic          hz_rt;
    logic          RegWrite;
    logic [4:0]    Write_register;
    logic [31:0]   Write_data;
    logic [AW:0]   q_count;
    logic          waw_err;

    regfile_write_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .chk_rs         (chk_rs),
        .chk_rt         (chk_rt),
        .hz_rs          (hz_rs),
        .hz_rt          (hz_rt),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .q_count        (q_count),
        .waw_err        (waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queued writes plus the visible write-port state.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_we   = 1'b0;
    logic [4:0]  m_wr   = '0;
    logic [31:0] m_wd   = '0;
    logic        m_waw  = 1'b0;
    bit          m_live = 1'b0;
    bit          m_acc;
    bit          m_wbf;
    bit          m_byp;
    ent_t        m_head;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic bit model_pending(input logic [4:0] r);
        if (r == 5'd0)
            return 1'b0;
        foreach (mq[i])
            if (mq[i].rd == r)
                return 1'b1;
        return m_we && (m_wr == r);
    endfunction

    // Advance the model on each rising edge from the inputs held across it.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_we   = 1'b0;
            m_wr   = '0;
            m_wd   = '0;
            m_waw  = 1'b0;
            m_live = 1'b1;
        end else begin
            m_acc = lu_valid && (mq.size() != DEPTH) && (lu_rd != 5'd0);
            m_wbf = wb_valid && (wb_rd != 5'd0);
            if (m_wbf)
                foreach (mq[i])
                    if (mq[i].rd == wb_rd)
                        m_waw = 1'b1;
`ifdef WSCHED_BYPASS_EN
            m_byp = m_acc && (mq.size() == 0) && !m_wbf;
`else
            m_byp = 1'b0;
`endif
            if (m_wbf) begin
                m_we = 1'b1; m_wr = wb_rd; m_wd = wb_data;
            end else if (mq.size() != 0) begin
                m_head = mq.pop_front();
                m_we = 1'b1; m_wr = m_head.rd; m_wd = m_head.data;
            end else if (m_byp) begin
                m_we = 1'b1; m_wr = lu_rd; m_wd = lu_data;
            end else begin
                m_we = 1'b0;
            end
            if (m_acc && !m_byp)
                mq.push_back('{rd: lu_rd, data: lu_data});
        end
    end

    // Compare every observable output against the model mid-cycle.
    always @(negedge clk) begin
        if (m_live) begin
            check("lu_ready", 32'(lu_ready), 32'(!reset && (mq.size() != DEPTH)));
            check("q_count", 32'(q_count), mq.size());
            check("RegWrite", 32'(RegWrite), 32'(m_we));
            check("Write_register", 32'(Write_register), 32'(m_wr));
            check("Write_data", Write_data, m_wd);
            check("waw_err", 32'(waw_err), 32'(m_waw));
            check("hz_rs", 32'(hz_rs), 32'(model_pending(chk_rs)));
            check("hz_rt", 32'(hz_rt), 32'(model_pending(chk_rt)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        wb_valid = v; wb_rd = r; wb_data = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] r, input logic [31:0] d);
        lu_valid = v; lu_rd = r; lu_data = d;
    endtask

    initial begin
        reset = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0);
        set_lu(1'b1, 5'd3, 32'hDEAD);
        chk_rs = 5'd0;
        chk_rt = 5'd0;

        // Reset held for two edges with lu_valid asserted.
        #1;
        check("t1_ready_in_reset", 32'(lu_ready), 32'd0);
        step(); step();
        check("t1_regwrite", 32'(RegWrite), 32'd0);
        check("t1_qcount", 32'(q_count), 32'd0);
        check("t1_ready", 32'(lu_ready), 32'd0);
        reset = 1'b0;
        set_lu(1'b0, 5'd0, 32'h0);
        #1;
        check("t1_ready_after", 32'(lu_ready), 32'd1);

        // WB only, then a WB write to $0.
        set_wb(1'b1, 5'd5, 32'h1234);
        step();
        check("t2_we", 32'(RegWrite), 32'd1);
        check("t2_wr", 32'(Write_register), 32'd5);
        check("t2_wd", Write_data, 32'h1234);
        set_wb(1'b1, 5'd0, 32'h9999);
        step();
        check("t2_we_r0", 32'(RegWrite), 32'd0);
        check("t2_wr_hold", 32'(Write_register), 32'd5);

        // lu writes queued behind three WB cycles.
        chk_rs = 5'd9;
        set_wb(1'b1, 5'd3, 32'h31); set_lu(1'b1, 5'd8, 32'hA);
        step();
        check("t3_wr0", 32'(Write_register), 32'd3);
        check("t3_q1", 32'(q_count), 32'd1);
        set_wb(1'b1, 5'd3, 32'h32); set_lu(1'b1, 5'd9, 32'hB);
        step();
        check("t3_q2", 32'(q_count), 32'd2);
        check("t3_hz9_queued", 32'(hz_rs), 32'd1);
        set_wb(1'b1, 5'd3, 32'h33); set_lu(1'b0, 5'd0, 32'h0);
        step();
        check("t3_wd3", Write_data, 32'h33);
        set_wb(1'b0, 5'd0, 32'h0);
        step();
        check("t3_wr8", 32'(Write_register), 32'd8);
        check("t3_wd8", Write_data, 32'hA);
        step();
        check("t3_wr9", 32'(Write_register), 32'd9);
        check("t3_wd9", Write_data, 32'hB);
        check("t3_hz9_outreg", 32'(hz_rs), 32'd1);
        step();
        check("t3_we_idle", 32'(RegWrite), 32'd0);
        check("t3_hz9_clear", 32'(hz_rs), 32'd0);

        // Fill the FIFO under WB pressure, refuse a fifth, then drain one.
        set_wb(1'b1, 5'd3, 32'h44);
        for (int i = 0; i < 4; i++) begin
            set_lu(1'b1, 5'(10 + i), 32'(32'h100 + i));
            step();
        end
        check("t4_full", 32'(q_count), 32'd4);
        check("t4_ready_full", 32'(lu_ready), 32'd0);
        set_lu(1'b1, 5'd14, 32'h200);
        step();
        check("t4_no_accept", 32'(q_count), 32'd4);
        set_wb(1'b0, 5'd0, 32'h0); set_lu(1'b0, 5'd0, 32'h0);
        step();
        check("t4_pop_one", 32'(q_count), 32'd3);
        check("t4_ready_again", 32'(lu_ready), 32'd1);
        check("t4_head", 32'(Write_register), 32'd10);
        step(); step(); step();
        check("t4_last", Write_data, 32'h103);
        check("t4_empty", 32'(q_count), 32'd0);

        // Push and pop on the same edge keep occupancy; order is preserved.
        chk_rs = 5'd0;
        set_wb(1'b1, 5'd3, 32'h55);
        set_lu(1'b1, 5'd15, 32'hF); step();
        set_lu(1'b1, 5'd16, 32'h10); step();
        check("t5_q2", 32'(q_count), 32'd2);
        set_wb(1'b0, 5'd0, 32'h0); set_lu(1'b1, 5'd12, 32'hC);
        step();
        check("t5_q_same", 32'(q_count), 32'd2);
        check("t5_wr15", 32'(Write_register), 32'd15);
        check("t5_hz_r0", 32'(hz_rs), 32'd0);
        set_lu(1'b0, 5'd0, 32'h0);
        step();
        check("t5_wr16", 32'(Write_register), 32'd16);
        step();
        check("t5_wr12", 32'(Write_register), 32'd12);
        check("t5_wd12", Write_data, 32'hC);

        // WAW against a queued entry sets the sticky flag.
        set_wb(1'b1, 5'd3, 32'h66); set_lu(1'b1, 5'd7, 32'h77);
        step();
        set_wb(1'b1, 5'd7, 32'h70); set_lu(1'b0, 5'd0, 32'h0);
        step();
        check("t6_waw", 32'(waw_err), 32'd1);
        check("t6_wb_emitted", Write_data, 32'h70);
        check("t6_fifo_kept", 32'(q_count), 32'd1);
        set_wb(1'b0, 5'd0, 32'h0);
        step();
        check("t6_queued_out", Write_data, 32'h77);
        step();
        check("t6_waw_sticky", 32'(waw_err), 32'd1);

        // Empty FIFO, idle WB: lu write latency.
        set_lu(1'b1, 5'd4, 32'h55);
        step();
        set_lu(1'b0, 5'd0, 32'h0);
`ifdef WSCHED_BYPASS_EN
        check("t6_byp_we", 32'(RegWrite), 32'd1);
        check("t6_byp_wd", Write_data, 32'h55);
        check("t6_byp_q", 32'(q_count), 32'd0);
`else
        check("t6_fifo_we", 32'(RegWrite), 32'd0);
        check("t6_fifo_q", 32'(q_count), 32'd1);
        step();
        check("t6_fifo_we2", 32'(RegWrite), 32'd1);
        check("t6_fifo_wd2", Write_data, 32'h55);
`endif
        step();

        // Reset mid-operation drops queued writes without emitting them.
        set_wb(1'b1, 5'd3, 32'h88);
        set_lu(1'b1, 5'd20, 32'h20); step();
        set_lu(1'b1, 5'd21, 32'h21); step();
        set_wb(1'b0, 5'd0, 32'h0); set_lu(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_q_cleared", 32'(q_count), 32'd0);
        check("t7_waw_cleared", 32'(waw_err), 32'd0);
        step();
        check("t7_no_emit", 32'(RegWrite), 32'd0);

        // Randomized traffic with alternating WB pressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            wb_valid = ($urandom_range(0, 99) < (((c / 300) % 2) != 0 ? 85 : 25));
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            lu_valid = ($urandom_range(0, 2) != 0);
            lu_rd    = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            chk_rs   = 5'($urandom_range(0, 7));
            chk_rt   = 5'($urandom_range(0, 31));
            step();
        end

        reset = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_lu(1'b0, 5'd0, 32'h0);
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
